// File: rtl/nand_not_pkg.sv
// Shared types and the bitwise NAND/NOT evaluator for nand_not_pipe.
package nand_not_pkg;

    localparam int STATS_W = 16;
    localparam int MAX_W   = 32;

    // Gate-for-gate image of the original netlist; callers truncate to their width.
    function automatic logic [MAX_W-1:0] nand_not_eval(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [MAX_W-1:0] c,
        input logic [MAX_W-1:0] d
    );
        logic [MAX_W-1:0] k_s;
        logic [MAX_W-1:0] l_s;
        logic [MAX_W-1:0] m_s;
        k_s = c | d;
        l_s = ~(a & b);
        m_s = ~(l_s & d);
        return ~(k_s & m_s);
    endfunction

endpackage

// File: rtl/nand_not_stage.sv
// One elastic pipeline slot: data register plus valid flag.
module nand_not_stage
    import nand_not_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // Advancing with no incoming data collapses a bubble; data only moves with a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else if (adv) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/nand_not_pipe.sv
// Elastic STAGES-deep pipeline around the NAND/NOT evaluator.
// Optional NAND_NOT_PIPE_STATS_EN adds a saturating output-transfer counter (xfer_count).
module nand_not_pipe
    import nand_not_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   w
`ifdef NAND_NOT_PIPE_STATS_EN
    ,
    output logic [STATS_W-1:0] xfer_count
`endif
);

    logic [WIDTH-1:0]  eval_s;
    logic [STAGES:0]   adv_s;
    logic [STAGES-1:0] stage_valid_s;
    logic [WIDTH-1:0]  stage_data_s [STAGES];

    assign eval_s = WIDTH'(nand_not_eval(MAX_W'(a), MAX_W'(b), MAX_W'(c), MAX_W'(d)));

    // A slot may move when it is empty or its occupant leaves this cycle.
    assign adv_s[STAGES] = out_ready;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        assign adv_s[s] = ~stage_valid_s[s] | adv_s[s+1];

        if (s == 0) begin : g_head
            nand_not_stage #(.WIDTH(WIDTH)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .adv      (adv_s[s]),
                .in_valid (in_valid),
                .in_data  (eval_s),
                .valid    (stage_valid_s[s]),
                .data     (stage_data_s[s])
            );
        end else begin : g_body
            nand_not_stage #(.WIDTH(WIDTH)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .adv      (adv_s[s]),
                .in_valid (stage_valid_s[s-1]),
                .in_data  (stage_data_s[s-1]),
                .valid    (stage_valid_s[s]),
                .data     (stage_data_s[s])
            );
        end
    end

    assign in_ready  = adv_s[0];
    assign out_valid = stage_valid_s[STAGES-1];
    assign w         = stage_data_s[STAGES-1];

`ifdef NAND_NOT_PIPE_STATS_EN
    logic [STATS_W-1:0] xfer_count_r;

    // Count accepted results, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_r <= {STATS_W{1'b0}};
        end else if (out_valid && out_ready && (xfer_count_r != {STATS_W{1'b1}})) begin
            xfer_count_r <= xfer_count_r + {{(STATS_W-1){1'b0}}, 1'b1};
        end else begin
            xfer_count_r <= xfer_count_r;
        end
    end

    assign xfer_count = xfer_count_r;
`endif

endmodule

// File: tb/tb_nand_not_pipe.sv
// Directed self-checking bench for nand_not_pipe (WIDTH=4, STAGES=2).
module tb_nand_not_pipe;

    localparam int WIDTH  = 4;
    localparam int STAGES = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] w;
`ifdef NAND_NOT_PIPE_STATS_EN
    logic [15:0]      xfer_count;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-computed vectors: w = ~((c|d) & ((a&b)|~d))
    logic [3:0] va [11] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1010, 4'b1111,
                            4'b1100, 4'b0110, 4'b1111, 4'b0001, 4'b1111};
    logic [3:0] vb [11] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1100, 4'b0000,
                            4'b1010, 4'b0011, 4'b0101, 4'b0001, 4'b1111};
    logic [3:0] vc [11] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0011, 4'b0000,
                            4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0000};
    logic [3:0] vd [11] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0101, 4'b1111,
                            4'b1111, 4'b0001, 4'b1010, 4'b0011, 4'b0000};
    logic [3:0] vw [11] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1101, 4'b1111,
                            4'b0111, 4'b0111, 4'b1011, 4'b1110, 4'b1111};

    nand_not_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .w          (w)
`ifdef NAND_NOT_PIPE_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feed n table vectors from index first; out_ready held low for the first stall cycles.
    task automatic stream(input int first, input int n, input int stall);
        int   sent = 0;
        int   rcv = 0;
        int   cyc = 0;
        int   first_seen = -1;
        int   last_seen = -1;
        int   sent_at_stall = 0;
        logic ir_at_stall = 1'b1;
        while (rcv < n && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            if (sent < n) begin
                in_valid = 1'b1;
                a = va[first+sent];
                b = vb[first+sent];
                c = vc[first+sent];
                d = vd[first+sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (first_seen < 0) first_seen = cyc;
                check("stream_w", 32'(w), 32'(vw[first+rcv]));
                if (out_ready) begin
                    rcv++;
                    last_seen = cyc;
                end
            end
            if (stall > 0 && cyc == stall - 1) begin
                ir_at_stall   = in_ready;
                sent_at_stall = sent;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 32'(rcv), 32'(n));
        check("stream_latency", 32'(first_seen), 32'(STAGES));
        if (stall == 0) begin
            check("stream_rate", 32'(last_seen), 32'(STAGES + n - 1));
        end else begin
            check("stall_in_ready", 32'(ir_at_stall), 32'd0);
            check("stall_accepts", 32'(sent_at_stall), 32'(STAGES));
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 4'b0000;
        b = 4'b0000;
        c = 4'b0000;
        d = 4'b0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_w", 32'(w), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        stream(4, 1, 0);
        @(negedge clk);
        #1;
        check("empty_out_valid", 32'(out_valid), 32'd0);
        check("empty_w_hold", 32'(w), 32'(vw[4]));

        stream(10, 1, 0);

        stream(0, 10, 0);

        stream(5, 5, 5);

        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = va[1]; b = vb[1]; c = vc[1]; d = vd[1];
        @(negedge clk);
        a = va[2]; b = vb[2]; c = vc[2]; d = vd[2];
        @(negedge clk);
        #1;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_w", 32'(w), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

`ifdef NAND_NOT_PIPE_STATS_EN
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        a = va[0]; b = vb[0]; c = vc[0]; d = vd[0];
        repeat (70005) @(posedge clk);
        @(negedge clk);
        #1;
        check("stats_saturate", 32'(xfer_count), 32'h0000_FFFF);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("stats_reset", 32'(xfer_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
